// File: rtl/serial_add_seq_if.sv
// Operand and result handshake bundle for the bit-serial add sequencer.
// The master drives operands and consumes results; the slave is the sequencer.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;

    modport master (
        output in_valid, in_a, in_b, in_ci, out_ready,
        input  in_ready, out_valid, out_sum, out_co
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci, out_ready,
        output in_ready, out_valid, out_sum, out_co
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: streams two operands LSB-first through an external
// 1-bit full adder and returns the collected sum and final carry.
module serial_add_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_seq_if.slave       bus,
    output logic                  fa_a_o,
    output logic                  fa_b_o,
    output logic                  fa_ci_o,
    input  logic                  fa_sum_i,
    input  logic                  fa_co_i
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_sh_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_co_q;

    // Next sum shadow: incoming adder bit enters at the MSB (also correct for WIDTH=1).
    always_comb begin
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_sum_i;
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_co_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_q     <= bus.in_a;
                        b_sh_q     <= bus.in_b;
                        carry_q    <= bus.in_ci;
                        sum_sh_q   <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_co_i;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Result is captured straight from the final adder cycle.
                        out_valid_q <= 1'b1;
                        out_sum_q   <= sum_sh_d;
                        out_co_q    <= fa_co_i;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_sum_q   <= '0;
                        out_co_q    <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_sum_q   <= '0;
                    out_co_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fa_a_o        = (state_q == ST_RUN) ? a_sh_q[0] : 1'b0;
    assign fa_b_o        = (state_q == ST_RUN) ? b_sh_q[0] : 1'b0;
    assign fa_ci_o       = (state_q == ST_RUN) ? carry_q   : 1'b0;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_co    = out_co_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq (WIDTH=8 and WIDTH=1) with a
// behavioural full adder closing the loop.
module tb_serial_add_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_seq_if #(.WIDTH(8)) bus ();
    serial_add_seq_if #(.WIDTH(1)) bus1 ();

    logic fa_a, fa_b, fa_ci, fa_sum, fa_co;
    logic g_a, g_b, g_ci, g_sum, g_co;

    assign fa_sum = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
    assign g_sum  = g_a ^ g_b ^ g_ci;
    assign g_co   = (g_a & g_b) | (g_a & g_ci) | (g_b & g_ci);

    serial_add_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fa_a_o(fa_a), .fa_b_o(fa_b), .fa_ci_o(fa_ci),
        .fa_sum_i(fa_sum), .fa_co_i(fa_co)
    );

    serial_add_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .fa_a_o(g_a), .fa_b_o(g_b), .fa_ci_o(g_ci),
        .fa_sum_i(g_sum), .fa_co_i(g_co)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    // Full operation on the WIDTH=8 instance with per-cycle adder-input checks.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] esum, input logic eco, input bit check_fa);
        int  lat;
        logic carry;
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_ci = ci;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_a = ~a; bus.in_b = a ^ b; bus.in_ci = ~ci;
        lat = 0; carry = ci;
        while (!bus.out_valid && lat < 40) begin
            if (check_fa && lat < 8) begin
                chk("fa_a", fa_a, a[lat]);
                chk("fa_b", fa_b, b[lat]);
                chk("fa_ci", fa_ci, carry);
                carry = (a[lat] & b[lat]) | (a[lat] & carry) | (b[lat] & carry);
            end
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("latency", lat, 8);
        chk("out_sum", bus.out_sum, esum);
        chk("out_co", bus.out_co, eco);
        chk("in_ready_done", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_clear", bus.out_valid, 0);
    endtask

    vec_t vecs[10];

    initial begin
        bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_ci = 1'b0;
        bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = 1'b0; bus1.in_b = 1'b0; bus1.in_ci = 1'b0;
        bus1.out_ready = 1'b0;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[9] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};

        // Reset state
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_co", bus.out_co, 0);
        chk("rst_fa", {fa_a, fa_b, fa_ci}, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co, 1'b1);

        // Backpressure: hold result for 5 cycles
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = 8'h5A; bus.in_b = 8'h33; bus.in_ci = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 40 && !bus.out_valid; k++) @(negedge clk);
        chk("bp_valid", bus.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_sum", {bus.out_co, bus.out_sum}, 9'h08D);
            chk("bp_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle_valid", bus.out_valid, 0);
        chk("bp_idle_ready", bus.in_ready, 1);

        // Reset in the middle of RUN (cnt==3)
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = 8'hC3; bus.in_b = 8'h3C; bus.in_ci = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_fa", {fa_a, fa_b, fa_ci}, 0);
        @(negedge clk); rst = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            chk("mid_rst_no_valid", seen, 0);
        end
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);

        // Random back-to-back against a reference adder
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] ref_sum;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            do_op(ra, rb, rc, ref_sum[7:0], ref_sum[8], (n < 50));
        end

        // WIDTH=1 instance
        begin
            logic [2:0] w1 [3];
            logic [1:0] w1e [3];
            w1[0] = 3'b111; w1e[0] = 2'b11;
            w1[1] = 3'b010; w1e[1] = 2'b01;
            w1[2] = 3'b101; w1e[2] = 2'b10;
            for (int i = 0; i < 3; i++) begin
                int lat;
                @(negedge clk);
                bus1.in_valid = 1'b1;
                bus1.in_a = w1[i][2]; bus1.in_b = w1[i][1]; bus1.in_ci = w1[i][0];
                @(posedge clk); @(negedge clk);
                bus1.in_valid = 1'b0;
                lat = 0;
                while (!bus1.out_valid && lat < 20) begin
                    @(posedge clk); lat++; @(negedge clk);
                end
                chk("w1_latency", lat, 1);
                chk("w1_result", {bus1.out_co, bus1.out_sum}, w1e[i]);
                bus1.out_ready = 1'b1;
                @(negedge clk);
                bus1.out_ready = 1'b0;
                chk("w1_idle", {bus1.in_ready, bus1.out_valid}, 2'b10);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
